// File: rtl/memory_arbiter.sv
// Two-core RAM arbiter: four requesters (instruction + data per core) share
// one RAM port. One transaction at a time; data beats instruction inside a
// core, and the cores alternate round-robin on each completed transfer.
module memory_arbiter #(
  parameter int WORD_W = 32,
  parameter int NCORES = 2   // the arbitration logic assumes exactly two cores
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NCORES-1:0]        iREN,
  input  logic [NCORES*WORD_W-1:0] iaddr,
  input  logic [NCORES-1:0]        dREN,
  input  logic [NCORES-1:0]        dWEN,
  input  logic [NCORES*WORD_W-1:0] daddr,
  input  logic [NCORES*WORD_W-1:0] dstore,
  output logic [NCORES-1:0]        iwait,
  output logic [NCORES-1:0]        dwait,
  output logic [NCORES*WORD_W-1:0] iload,
  output logic [NCORES*WORD_W-1:0] dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {IDLE, XFER} state_t;

  // Per-core views of the packed request buses
  logic [WORD_W-1:0] iaddr_w  [NCORES];
  logic [WORD_W-1:0] daddr_w  [NCORES];
  logic [WORD_W-1:0] dstore_w [NCORES];
  logic [NCORES-1:0] req_d;     // data channel requesting
  logic [NCORES-1:0] core_req;  // any channel of the core requesting
  logic [NCORES-1:0] done_i;
  logic [NCORES-1:0] done_d;

  // Registered state
  state_t            state_q, state_d;
  logic              rr_q, rr_d;        // core favoured when both request
  logic              owner_q, owner_d;  // core holding the grant
  logic              data_q, data_d;    // grant belongs to the data channel
  logic              wr_q, wr_d;        // granted transfer is a write
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;

  // Arbitration result, only consumed while IDLE
  logic              sel_core;
  logic              sel_data;
  logic              sel_wr;
  logic [WORD_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_store;
  logic              xfer_done;

  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_core
      assign iaddr_w[gi]  = iaddr[gi*WORD_W +: WORD_W];
      assign daddr_w[gi]  = daddr[gi*WORD_W +: WORD_W];
      assign dstore_w[gi] = dstore[gi*WORD_W +: WORD_W];
      assign req_d[gi]    = dREN[gi] | dWEN[gi];
      assign core_req[gi] = req_d[gi] | iREN[gi];

      // done is a single-cycle strobe to whichever channel owns the grant
      assign done_i[gi] = xfer_done & (owner_q == 1'(gi)) & ~data_q;
      assign done_d[gi] = xfer_done & (owner_q == 1'(gi)) &  data_q;

      assign iwait[gi] = iREN[gi] & ~done_i[gi];
      assign dwait[gi] = req_d[gi] & ~done_d[gi];

      // Read data is forwarded only in the owner's done cycle of a read
      assign iload[gi*WORD_W +: WORD_W] = (done_i[gi] & ~wr_q) ? ramload : '0;
      assign dload[gi*WORD_W +: WORD_W] = (done_d[gi] & ~wr_q) ? ramload : '0;
    end
  endgenerate

  assign xfer_done = (state_q == XFER) && (ramstate == RAM_ACCESS);

  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  // Pick the core (round-robin on contention) and its channel (data first)
  always_comb begin
    sel_core = 1'b0;
    if (core_req[0] && core_req[1]) begin
      sel_core = rr_q;
    end else begin
      sel_core = core_req[1];
    end
    sel_data  = req_d[sel_core];
    sel_wr    = sel_data & dWEN[sel_core];
    sel_addr  = sel_data ? daddr_w[sel_core] : iaddr_w[sel_core];
    sel_store = sel_data ? dstore_w[sel_core] : '0;
  end

  // Next-state logic: grant in IDLE, hold in XFER until the RAM reports ACCESS
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    data_d  = data_q;
    wr_d    = wr_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    store_d = store_q;
    case (state_q)
      IDLE: begin
        if (|core_req) begin
          state_d = XFER;
          owner_d = sel_core;
          data_d  = sel_data;
          wr_d    = sel_wr;
          ren_d   = ~sel_wr;
          wen_d   = sel_wr;
          addr_d  = sel_addr;
          store_d = sel_store;
        end
      end
      XFER: begin
        // BUSY, FREE and ERROR all keep the same outputs driven (retry)
        if (xfer_done) begin
          state_d = IDLE;
          rr_d    = ~owner_q;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          addr_d  = '0;
          store_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered RAM outputs; reset aborts any transfer in flight
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      data_q  <= 1'b0;
      wr_q    <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      store_q <= store_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small word-addressed RAM model.
module tb_memory_arbiter;
  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait;
  logic [63:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  logic [31:0] mem [64];
  logic        ram_auto;
  logic [1:0]  ram_force;
  int nvec = 0;
  int nerr = 0;

  memory_arbiter #(.WORD_W(32), .NCORES(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // RAM model: single-cycle ACCESS in auto mode, otherwise forced status
  assign ramstate = ram_auto ? ((ramREN | ramWEN) ? 2'd2 : 2'd0) : ram_force;
  assign ramload  = mem[ramaddr[7:2]];
  always @(posedge CLK) if (ramWEN && ramstate == 2'd2) mem[ramaddr[7:2]] <= ramstore;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ram_auto = 1'b1; ram_force = 2'd0;
    repeat (2) @(posedge CLK);
    #1;
    nvec++; if (ramREN !== 1'b0) begin nerr++; $display("FAIL reset_ramREN got %b exp 0", ramREN); end
    nvec++; if (ramWEN !== 1'b0) begin nerr++; $display("FAIL reset_ramWEN got %b exp 0", ramWEN); end
    nvec++; if (ramaddr !== 32'h0) begin nerr++; $display("FAIL reset_ramaddr got %h exp 0", ramaddr); end
    nvec++; if (ramstore !== 32'h0) begin nerr++; $display("FAIL reset_ramstore got %h exp 0", ramstore); end
    dREN = 2'b01; iREN = 2'b10;
    #1;
    nvec++; if (dwait !== 2'b01 || iwait !== 2'b10) begin nerr++; $display("FAIL reset_waits got d=%b i=%b exp d=01 i=10", dwait, iwait); end
    nvec++; if (dload !== 64'h0 || iload !== 64'h0) begin nerr++; $display("FAIL reset_loads got d=%h i=%h exp 0", dload, iload); end
    dREN = 0; iREN = 0;
    tick();
    nRST = 1'b1;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_single_read();
    daddr[31:0] = 32'h4; dREN = 2'b01;
    #1;
    nvec++; if (dwait !== 2'b01 || ramREN !== 1'b0) begin nerr++; $display("FAIL rd_idle got dwait=%b ren=%b exp 01/0", dwait, ramREN); end
    tick();
    nvec++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h4) begin nerr++; $display("FAIL rd_bus got ren=%b wen=%b addr=%h exp 1/0/4", ramREN, ramWEN, ramaddr); end
    nvec++; if (dwait !== 2'b00) begin nerr++; $display("FAIL rd_dwait got %b exp 00", dwait); end
    nvec++; if (dload !== 64'h00000000_1234ABCD) begin nerr++; $display("FAIL rd_dload got %h exp 000000001234abcd", dload); end
    dREN = 0;
    tick();
    nvec++; if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin nerr++; $display("FAIL rd_back_idle got ren=%b addr=%h exp 0/0", ramREN, ramaddr); end
    $display("txn single read core0 addr=0x4 dload=%h", 32'h1234ABCD);
  endtask

  task automatic test_write_readback();
    daddr[63:32] = 32'h0; dstore[63:32] = 32'h0ABCDEF9; dWEN = 2'b10;
    tick();
    nvec++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin nerr++; $display("FAIL wr_en got wen=%b ren=%b exp 1/0", ramWEN, ramREN); end
    nvec++; if (ramstore !== 32'h0ABCDEF9 || ramaddr !== 32'h0) begin nerr++; $display("FAIL wr_bus got store=%h addr=%h exp 0abcdef9/0", ramstore, ramaddr); end
    nvec++; if (dwait !== 2'b00 || dload !== 64'h0) begin nerr++; $display("FAIL wr_done got dwait=%b dload=%h exp 00/0", dwait, dload); end
    dWEN = 0;
    tick();
    dREN = 2'b10;
    tick();
    nvec++; if (dload !== 64'h0ABCDEF9_00000000) begin nerr++; $display("FAIL wr_readback got %h exp 0abcdef900000000", dload); end
    dREN = 0;
    tick();
    $display("txn write+readback core1 addr=0x0 data=%h", 32'h0ABCDEF9);
  endtask

  task automatic test_contention();
    logic [31:0] exp_addr, exp_data;
    int exp_core;
    daddr = {32'hC, 32'h8}; dREN = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_core = t % 2;
      exp_addr = (exp_core == 1) ? 32'hC : 32'h8;
      exp_data = mem[exp_addr[7:2]];
      #1;
      nvec++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin nerr++; $display("FAIL cont_idle%0d got ren=%b dwait=%b exp 0/11", t, ramREN, dwait); end
      tick();
      nvec++; if (ramaddr !== exp_addr) begin nerr++; $display("FAIL cont_grant%0d got addr=%h exp %h", t, ramaddr, exp_addr); end
      nvec++; if (dwait !== ((exp_core == 1) ? 2'b01 : 2'b10)) begin nerr++; $display("FAIL cont_dwait%0d got %b exp core %0d done", t, dwait, exp_core); end
      nvec++; if (dload !== ((exp_core == 1) ? {exp_data, 32'h0} : {32'h0, exp_data})) begin nerr++; $display("FAIL cont_dload%0d got %h exp word %h on core %0d", t, dload, exp_data, exp_core); end
      $display("txn contention %0d granted core%0d addr=%h", t, exp_core, ramaddr);
      tick();
    end
    dREN = 0;
    #1;
  endtask

  task automatic test_intra_priority();
    iaddr[31:0] = 32'h10; daddr[31:0] = 32'h20; iREN = 2'b01; dREN = 2'b01;
    tick();
    nvec++; if (ramaddr !== 32'h20) begin nerr++; $display("FAIL prio_first got addr=%h exp 20", ramaddr); end
    nvec++; if (dwait !== 2'b00 || iwait !== 2'b01) begin nerr++; $display("FAIL prio_waits1 got d=%b i=%b exp 00/01", dwait, iwait); end
    nvec++; if (dload !== {32'h0, 32'h22220020} || iload !== 64'h0) begin nerr++; $display("FAIL prio_load1 got d=%h i=%h exp 22220020/0", dload, iload); end
    dREN = 0;
    tick();
    nvec++; if (iwait !== 2'b01 || ramREN !== 1'b0) begin nerr++; $display("FAIL prio_gap got iwait=%b ren=%b exp 01/0", iwait, ramREN); end
    tick();
    nvec++; if (ramaddr !== 32'h10 || iwait !== 2'b00) begin nerr++; $display("FAIL prio_second got addr=%h iwait=%b exp 10/00", ramaddr, iwait); end
    nvec++; if (iload !== {32'h0, 32'h11110010}) begin nerr++; $display("FAIL prio_iload got %h exp 0000000011110010", iload); end
    iREN = 0;
    tick();
    $display("txn intra-core priority core0 data 0x20 then instr 0x10");
  endtask

  task automatic test_retry();
    int done_cnt = 0;
    ram_auto = 1'b0; ram_force = 2'd1;
    iaddr[63:32] = 32'h10; iREN = 2'b10;
    tick();
    for (int k = 0; k < 6; k++) begin
      ram_force = (k < 3) ? 2'd1 : ((k < 5) ? 2'd3 : 2'd2);
      #1;
      nvec++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h10) begin nerr++; $display("FAIL retry_bus%0d got ren=%b wen=%b addr=%h exp 1/0/10", k, ramREN, ramWEN, ramaddr); end
      if (iwait[1] == 1'b0) done_cnt++;
      if (k < 5) begin
        nvec++; if (iwait !== 2'b10 || iload !== 64'h0) begin nerr++; $display("FAIL retry_hold%0d got iwait=%b iload=%h exp 10/0", k, iwait, iload); end
      end else begin
        nvec++; if (iload !== {32'h11110010, 32'h0}) begin nerr++; $display("FAIL retry_iload got %h exp 1111001000000000", iload); end
        iREN = 0;
      end
      tick();
    end
    nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL retry_done_count got %0d exp 1", done_cnt); end
    nvec++; if (ramREN !== 1'b0) begin nerr++; $display("FAIL retry_idle got ren=%b exp 0", ramREN); end
    ram_auto = 1'b1;
    $display("txn retry busy x3 error x2 access, done pulses=%0d", done_cnt);
  endtask

  task automatic test_reset_mid();
    // A core0 completion first moves the round-robin pointer to core1
    daddr = {32'hC, 32'h8}; dREN = 2'b01;
    tick();
    dREN = 0;
    tick();
    ram_auto = 1'b0; ram_force = 2'd1; dREN = 2'b10;
    tick();
    nvec++; if (ramREN !== 1'b1 || ramaddr !== 32'hC) begin nerr++; $display("FAIL rst_xfer got ren=%b addr=%h exp 1/c", ramREN, ramaddr); end
    nRST = 1'b0; dREN = 2'b11;
    #1;
    nvec++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin nerr++; $display("FAIL rst_abort got ren=%b wen=%b addr=%h exp 0/0/0", ramREN, ramWEN, ramaddr); end
    nvec++; if (dwait !== 2'b11) begin nerr++; $display("FAIL rst_dwait got %b exp 11", dwait); end
    tick();
    nRST = 1'b1; ram_auto = 1'b1;
    #1;
    nvec++; if (ramREN !== 1'b0) begin nerr++; $display("FAIL rst_idle got ren=%b exp 0", ramREN); end
    tick();
    nvec++; if (ramaddr !== 32'h8 || dwait !== 2'b10) begin nerr++; $display("FAIL rst_rearb got addr=%h dwait=%b exp 8/10", ramaddr, dwait); end
    dREN = 0;
    tick();
    $display("txn reset mid-transfer, re-arbitrated to core0 addr=%h", 32'h8);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD0000 | i;
    mem[1] = 32'h1234ABCD;
    mem[2] = 32'hAAAA0008;
    mem[3] = 32'hBBBB000C;
    mem[4] = 32'h11110010;
    mem[8] = 32'h22220020;
    test_reset();
    test_single_read();
    test_write_readback();
    test_contention();
    test_intra_priority();
    test_retry();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
